rd_arbiter: RTL and testbench

RD_ARBITER -- requirements
Module: rd_arbiter

---
 rtl/rd_arbiter.sv | 145 ++++++++++++++
 tb/tb_rd_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_arbiter.sv
// Round-robin read arbiter over N ray-direction FIFOs.
//
// Picks one eligible channel at a time and strobes its FIFO for one cycle. The
// FIFO presents the ray on the next cycle, where it is captured and forwarded
// downstream. The ray is held stable until it is accepted.
//
// A RayDirection is three WIDTH-bit components (x, y, z), packed as {x, y, z}.
//
// Parameters
//   WIDTH          bit width of each RayDirection component
//   N              number of FIFO channels (2..8)
// Ports
//   clk            clock, rising edge
//   reset          synchronous active-low reset
//   enable_in      per-channel enable mask
//   fifo_ready_in  per-channel FIFO non-empty flags
//   fifo_rd_in     per-channel FIFO registered outputs
//   fifo_read_out  per-channel read strobes (at most one set)
//   rd_out         forwarded ray direction
//   rd_valid_out   rd_out holds a valid ray
//   rd_ready_in    downstream accepts rd_out this cycle
//   grant_id_out   channel index of the ray on rd_out
//   ray_count_out  rays accepted downstream, modulo 2^16
`ifndef WIDTH
`define WIDTH 16
`endif

module rd_arbiter #(
   parameter int unsigned WIDTH = `WIDTH,
   parameter int unsigned N     = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [N-1:0]                    enable_in,
   input  logic [N-1:0]                    fifo_ready_in,
   input  logic [N-1:0][3*WIDTH-1:0]       fifo_rd_in,
   output logic [N-1:0]                    fifo_read_out,
   output logic [3*WIDTH-1:0]              rd_out,
   output logic                            rd_valid_out,
   input  logic                            rd_ready_in,
   output logic [$clog2(N)-1:0]            grant_id_out,
   output logic [15:0]                     ray_count_out
);

   localparam int unsigned IdW = $clog2(N);

   typedef enum logic [1:0] {StIdle, StFetch, StSend} state_e;

   state_e               state_q, state_d;
   logic [IdW-1:0]       last_q, last_d;
   logic [IdW-1:0]       grant_q, grant_d;
   logic [3*WIDTH-1:0]   rd_q, rd_d;
   logic                 valid_q, valid_d;
   logic [15:0]          count_q, count_d;
   logic [N-1:0]         strobe;

   logic [N-1:0]         eligible;
   logic [IdW-1:0]       winner;
   logic                 found;

   assign eligible = fifo_ready_in & enable_in;

   // Search upward from the channel after the last grant, wrapping around.
   always_comb begin
      int idx;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 1; k <= int'(N); k++) begin
         idx = (int'(last_q) + k) % int'(N);
         if (!found && eligible[idx]) begin
            found  = 1'b1;
            winner = IdW'(idx);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      grant_d = grant_q;
      rd_d    = rd_q;
      valid_d = valid_q;
      count_d = count_q;
      strobe  = '0;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               strobe[winner] = 1'b1;
               last_d         = winner;
               grant_d        = winner;
               state_d        = StFetch;
            end
         end
         StFetch: begin
            // FIFO output is valid now, one cycle after its strobe.
            rd_d    = fifo_rd_in[grant_q];
            valid_d = 1'b1;
            state_d = StSend;
         end
         StSend: begin
            if (rd_ready_in) begin
               count_d = count_q + 16'd1;
               valid_d = 1'b0;
               if (found) begin
                  // Overlap the next fetch with the accept to sustain one ray per two cycles.
                  strobe[winner] = 1'b1;
                  last_d         = winner;
                  grant_d        = winner;
                  state_d        = StFetch;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= StIdle;
         last_q  <= IdW'(N - 1);
         grant_q <= '0;
         rd_q    <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         rd_q    <= rd_d;
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   // Strobes are suppressed while reset is held so no FIFO loses a ray.
   assign fifo_read_out = reset ? strobe : '0;
   assign rd_out        = rd_q;
   assign rd_valid_out  = valid_q;
   assign grant_id_out  = grant_q;
   assign ray_count_out = count_q;

endmodule

// File: tb/tb_rd_arbiter.sv
module tb_rd_arbiter;

   localparam int W = 16;
   localparam int N = 4;

   typedef struct packed {
      logic [1:0]     id;
      logic [3*W-1:0] data;
   } exp_t;

   logic                    clk;
   logic                    reset;
   logic [N-1:0]            enable_in;
   logic [N-1:0]            fifo_ready_in;
   logic [N-1:0][3*W-1:0]   fifo_rd;
   logic [N-1:0]            fifo_read_out;
   logic [3*W-1:0]          rd_out;
   logic                    rd_valid_out;
   logic                    rd_ready_in;
   logic [1:0]              grant_id_out;
   logic [15:0]             ray_count_out;

   int unsigned rd_cnt  [N];
   int unsigned exp_cnt [N];
   exp_t        exp_q [$];
   exp_t        e;
   int          n_checks = 0;
   int          n_pass   = 0;

   rd_arbiter #(.WIDTH(W), .N(N)) dut (
      .clk           (clk),
      .reset         (reset),
      .enable_in     (enable_in),
      .fifo_ready_in (fifo_ready_in),
      .fifo_rd_in    (fifo_rd),
      .fifo_read_out (fifo_read_out),
      .rd_out        (rd_out),
      .rd_valid_out  (rd_valid_out),
      .rd_ready_in   (rd_ready_in),
      .grant_id_out  (grant_id_out),
      .ray_count_out (ray_count_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3*W-1:0] make_data(int ch, int unsigned k);
      return {16'(ch + 16'h0100), 16'(k), 16'hA5A5 ^ 16'(k * 7 + 32'(ch))};
   endfunction

   // FIFO model: registered output updated on the cycle after a strobe.
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (!reset) rd_cnt[i] <= 0;
         else if (fifo_read_out[i]) begin
            fifo_rd[i] <= make_data(i, rd_cnt[i]);
            rd_cnt[i]  <= rd_cnt[i] + 1;
         end
      end
   end

   task automatic push_exp(int ch);
      exp_q.push_back({2'(ch), make_data(ch, exp_cnt[ch])});
      exp_cnt[ch]++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; enable_in = '0; fifo_ready_in = '0; rd_ready_in = 1'b0;
      exp_q.delete();
      for (int i = 0; i < N; i++) exp_cnt[i] = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (fifo_read_out !== 4'h0) $display("FAIL reset_strobe got %h want 0", fifo_read_out); else n_pass++;
      n_checks++; if (rd_valid_out !== 1'b0) $display("FAIL reset_valid got %b want 0", rd_valid_out); else n_pass++;
      n_checks++; if (rd_out !== '0) $display("FAIL reset_rd got %h want 0", rd_out); else n_pass++;
      n_checks++; if (grant_id_out !== 2'd0) $display("FAIL reset_grant got %0d want 0", grant_id_out); else n_pass++;
      n_checks++; if (ray_count_out !== 16'd0) $display("FAIL reset_count got %0d want 0", ray_count_out); else n_pass++;
   endtask

   task automatic test_single();
      do_reset();
      reset = 1'b1; enable_in = 4'hF; fifo_ready_in = 4'b0001;
      #1;
      n_checks++; if (fifo_read_out !== 4'b0001) $display("FAIL single_strobe got %b want 0001", fifo_read_out); else n_pass++;
      push_exp(0);
      @(negedge clk);
      // Channel disabled after its strobe must still deliver.
      enable_in = 4'h0; fifo_ready_in = 4'h0;
      n_checks++; if (fifo_read_out !== 4'h0) $display("FAIL single_fetch_strobe got %b want 0000", fifo_read_out); else n_pass++;
      n_checks++; if (rd_valid_out !== 1'b0) $display("FAIL single_fetch_valid got %b want 0", rd_valid_out); else n_pass++;
      @(negedge clk);
      n_checks++; if (rd_valid_out !== 1'b1) $display("FAIL single_valid got %b want 1", rd_valid_out); else n_pass++;
      rd_ready_in = 1'b1;
      e = exp_q.pop_front();
      n_checks++; if (grant_id_out !== e.id) $display("FAIL single_grant got %0d want %0d", grant_id_out, e.id); else n_pass++;
      n_checks++; if (rd_out !== e.data) $display("FAIL single_data got %h want %h", rd_out, e.data); else n_pass++;
      @(negedge clk);
      rd_ready_in = 1'b0;
      n_checks++; if (rd_valid_out !== 1'b0) $display("FAIL single_cleared got %b want 0", rd_valid_out); else n_pass++;
      n_checks++; if (ray_count_out !== 16'd1) $display("FAIL single_count got %0d want 1", ray_count_out); else n_pass++;
   endtask

   task automatic test_round_robin();
      int accepts = 0;
      int last_cyc = -1;
      do_reset();
      reset = 1'b1; enable_in = 4'hF; fifo_ready_in = 4'hF; rd_ready_in = 1'b1;
      push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
      for (int cyc = 0; cyc < 40 && accepts < 5; cyc++) begin
         #1;
         if (rd_valid_out && rd_ready_in && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++; if (grant_id_out !== e.id) $display("FAIL rr_grant got %0d want %0d", grant_id_out, e.id); else n_pass++;
            n_checks++; if (rd_out !== e.data) $display("FAIL rr_data got %h want %h", rd_out, e.data); else n_pass++;
            if (last_cyc >= 0) begin
               n_checks++; if (cyc - last_cyc !== 2) $display("FAIL rr_interval got %0d want 2", cyc - last_cyc); else n_pass++;
            end
            last_cyc = cyc;
            accepts++;
         end
         @(negedge clk);
      end
      fifo_ready_in = 4'h0; rd_ready_in = 1'b0;
      n_checks++; if (accepts !== 5) $display("FAIL rr_accepts got %0d want 5", accepts); else n_pass++;
      n_checks++; if (ray_count_out !== 16'd5) $display("FAIL rr_count got %0d want 5", ray_count_out); else n_pass++;
   endtask

   task automatic test_stall();
      int waited = 0;
      do_reset();
      reset = 1'b1; enable_in = 4'hF; fifo_ready_in = 4'b0001;
      push_exp(0);
      while (!rd_valid_out && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      n_checks++; if (rd_valid_out !== 1'b1) $display("FAIL stall_wait got %b want 1", rd_valid_out); else n_pass++;
      fifo_ready_in = 4'hF;
      e = exp_q.pop_front();
      for (int i = 0; i < 10; i++) begin
         #1;
         n_checks++; if (rd_valid_out !== 1'b1) $display("FAIL stall_valid got %b want 1", rd_valid_out); else n_pass++;
         n_checks++; if (rd_out !== e.data) $display("FAIL stall_data got %h want %h", rd_out, e.data); else n_pass++;
         n_checks++; if (grant_id_out !== e.id) $display("FAIL stall_grant got %0d want %0d", grant_id_out, e.id); else n_pass++;
         n_checks++; if (fifo_read_out !== 4'h0) $display("FAIL stall_strobe got %b want 0000", fifo_read_out); else n_pass++;
         n_checks++; if (ray_count_out !== 16'd0) $display("FAIL stall_count got %0d want 0", ray_count_out); else n_pass++;
         @(negedge clk);
      end
      rd_ready_in = 1'b1;
      #1;
      // Round-robin continues after channel 0.
      n_checks++; if (fifo_read_out !== 4'b0010) $display("FAIL stall_next_strobe got %b want 0010", fifo_read_out); else n_pass++;
      @(negedge clk);
      rd_ready_in = 1'b0; fifo_ready_in = 4'h0;
      n_checks++; if (ray_count_out !== 16'd1) $display("FAIL stall_count_after got %0d want 1", ray_count_out); else n_pass++;
   endtask

   task automatic test_enable_mask();
      int accepts = 0;
      do_reset();
      reset = 1'b1; enable_in = 4'b0100; fifo_ready_in = 4'hF; rd_ready_in = 1'b1;
      push_exp(2); push_exp(2); push_exp(2);
      for (int cyc = 0; cyc < 30 && accepts < 3; cyc++) begin
         #1;
         n_checks++; if ((fifo_read_out & 4'b1011) !== 4'h0) $display("FAIL mask_strobe got %b want only bit 2", fifo_read_out); else n_pass++;
         if (rd_valid_out && rd_ready_in && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++; if (grant_id_out !== e.id) $display("FAIL mask_grant got %0d want %0d", grant_id_out, e.id); else n_pass++;
            n_checks++; if (rd_out !== e.data) $display("FAIL mask_data got %h want %h", rd_out, e.data); else n_pass++;
            accepts++;
         end
         @(negedge clk);
      end
      fifo_ready_in = 4'h0; rd_ready_in = 1'b0;
      n_checks++; if (accepts !== 3) $display("FAIL mask_accepts got %0d want 3", accepts); else n_pass++;
   endtask

   task automatic test_wrap();
      int waited = 0;
      do_reset();
      reset = 1'b1;
      @(negedge clk);
      force dut.count_q = 16'hFFFF;
      @(posedge clk);
      @(negedge clk);
      release dut.count_q;
      n_checks++; if (ray_count_out !== 16'hFFFF) $display("FAIL wrap_preload got %h want ffff", ray_count_out); else n_pass++;
      enable_in = 4'b0001; fifo_ready_in = 4'b0001; rd_ready_in = 1'b1;
      push_exp(0);
      while (!rd_valid_out && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      fifo_ready_in = 4'h0;
      n_checks++; if (rd_valid_out !== 1'b1) $display("FAIL wrap_wait got %b want 1", rd_valid_out); else n_pass++;
      e = exp_q.pop_front();
      n_checks++; if (rd_out !== e.data) $display("FAIL wrap_data got %h want %h", rd_out, e.data); else n_pass++;
      @(negedge clk);
      rd_ready_in = 1'b0;
      n_checks++; if (ray_count_out !== 16'h0000) $display("FAIL wrap_count got %h want 0000", ray_count_out); else n_pass++;
   endtask

   task automatic test_reset_fetch();
      do_reset();
      reset = 1'b1; enable_in = 4'hF; fifo_ready_in = 4'b0001; rd_ready_in = 1'b1;
      #1;
      n_checks++; if (fifo_read_out !== 4'b0001) $display("FAIL rf_strobe got %b want 0001", fifo_read_out); else n_pass++;
      @(negedge clk);
      reset = 1'b0; fifo_ready_in = 4'h0;
      @(negedge clk);
      n_checks++; if (rd_valid_out !== 1'b0) $display("FAIL rf_valid got %b want 0", rd_valid_out); else n_pass++;
      n_checks++; if (rd_out !== '0) $display("FAIL rf_data got %h want 0", rd_out); else n_pass++;
      n_checks++; if (fifo_read_out !== 4'h0) $display("FAIL rf_reset_strobe got %b want 0000", fifo_read_out); else n_pass++;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++; if (rd_valid_out !== 1'b0) $display("FAIL rf_never_valid got %b want 0", rd_valid_out); else n_pass++;
         n_checks++; if (fifo_read_out !== 4'h0) $display("FAIL rf_idle_strobe got %b want 0000", fifo_read_out); else n_pass++;
         @(negedge clk);
      end
      rd_ready_in = 1'b0;
      n_checks++; if (ray_count_out !== 16'd0) $display("FAIL rf_count got %0d want 0", ray_count_out); else n_pass++;
   endtask

   initial begin
      reset = 1'b0; enable_in = '0; fifo_ready_in = '0; rd_ready_in = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_enable_mask();
      test_wrap();
      test_reset_fetch();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
